command_sequencer: RTL and testbench

COMMAND_SEQUENCER -- requirements
Module: command_sequencer

---
 rtl/command_sequencer_pkg.sv | 17 +
 rtl/command_sequencer_record_stage.sv | 25 ++
 rtl/command_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_command_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/command_sequencer_pkg.sv
// Shared command codes, record sizing and sequencer state encoding.
package beagleg;

    localparam int unsigned MotionSegmentBits = 128;

    localparam logic [7:0] CMD_STATUS       = 8'h01;
    localparam logic [7:0] CMD_WRITE_FIFO   = 8'h02;
    localparam logic [7:0] CMD_CLEAR_ERRORS = 8'h03;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        COMMIT  = 2'd2,
        DISCARD = 2'd3
    } state_t;

endpackage

// File: rtl/command_sequencer_record_stage.sv
// Staging buffer holding one motion-segment record, written and read by byte index.
module record_stage #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 8,
    localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IdxW-1:0]  wr_idx,
    input  logic [Width-1:0] wr_data,
    input  logic [IdxW-1:0]  rd_idx,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/command_sequencer.sv
// SPI command sequencer: stages motion-segment records and commits whole records to the FIFO.
module command_sequencer
    import beagleg::*;
#(
    parameter int unsigned FifoDepth   = 16,
    parameter int unsigned RecordWords = beagleg::MotionSegmentBits / 8,
    localparam int unsigned SizeW      = $clog2(FifoDepth * RecordWords) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    input  logic [SizeW-1:0] fifo_size,
    output logic             fifo_write_en,
    output logic [7:0]       fifo_data,
    output logic [1:0]       state_o
);

    localparam int unsigned IdxW = $clog2(RecordWords);

    state_t          state, state_next;
    logic [IdxW-1:0] idx;
    logic            skid_full;
    logic [7:0]      skid_byte;
    logic            commit_abort;
    logic            err_overflow, err_truncate;
    logic            set_ovf, set_trunc, clr_err;
    logic            rx_ok, last, end_idle;
    logic [31:0]     used_records;
    logic [4:0]      empty_slots;

    logic            stage_wr_en;
    logic [IdxW-1:0] stage_wr_idx;
    logic [7:0]      stage_wr_data;
    logic [7:0]      stage_rd_data;

    record_stage #(
        .Depth (RecordWords),
        .Width (8)
    ) u_stage (
        .clk     (clk),
        .wr_en   (stage_wr_en),
        .wr_idx  (stage_wr_idx),
        .wr_data (stage_wr_data),
        .rd_idx  (idx),
        .rd_data (stage_rd_data)
    );

    assign rx_ok    = rx_valid && !cs;
    assign last     = (idx == IdxW'(RecordWords - 1));
    assign end_idle = commit_abort || cs;

    // Ceiling division in 32 bits so a nearly-full FIFO cannot wrap the slot count.
    assign used_records = (32'(fifo_size) + RecordWords - 1) / RecordWords;
    assign empty_slots  = (used_records >= FifoDepth) ? '0 : 5'(FifoDepth - used_records);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_ok) begin
                    if (rx_data == CMD_WRITE_FIFO) begin
                        state_next = RECEIVE;
                    end else if (rx_data != CMD_STATUS && rx_data != CMD_CLEAR_ERRORS) begin
                        state_next = DISCARD;
                    end
                end
            end
            RECEIVE: begin
                if (cs) begin
                    state_next = IDLE;
                end else if (rx_valid && last && empty_slots != '0) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                if (last) begin
                    state_next = end_idle ? IDLE : RECEIVE;
                end
            end
            DISCARD: begin
                if (cs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_write_en = (state == COMMIT);
        fifo_data     = (state == COMMIT) ? stage_rd_data : 8'h00;
        tx_data       = (state == IDLE) ? {err_overflow, err_truncate, 1'b0, empty_slots} : 8'h00;
        state_o       = state;
    end

    // Staging writes and error events; the skid byte is moved into entry 0 on the
    // final COMMIT cycle, after entry 0 has already been read out.
    always_comb begin
        set_ovf       = 1'b0;
        set_trunc     = 1'b0;
        clr_err       = 1'b0;
        stage_wr_en   = 1'b0;
        stage_wr_idx  = idx;
        stage_wr_data = rx_data;
        case (state)
            IDLE: begin
                clr_err = rx_ok && (rx_data == CMD_CLEAR_ERRORS);
            end
            RECEIVE: begin
                if (cs) begin
                    set_trunc = (idx != '0);
                end else if (rx_valid) begin
                    stage_wr_en = 1'b1;
                    set_ovf     = last && (empty_slots == '0);
                end
            end
            COMMIT: begin
                set_ovf = rx_ok && skid_full;
                if (last) begin
                    if (end_idle) begin
                        set_trunc = skid_full || rx_ok;
                    end else if (skid_full || rx_ok) begin
                        stage_wr_en   = 1'b1;
                        stage_wr_idx  = '0;
                        stage_wr_data = skid_full ? skid_byte : rx_data;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            skid_full    <= 1'b0;
            skid_byte    <= '0;
            commit_abort <= 1'b0;
            err_overflow <= 1'b0;
            err_truncate <= 1'b0;
        end else begin
            err_overflow <= set_ovf || (err_overflow && !clr_err);
            err_truncate <= set_trunc || (err_truncate && !clr_err);
            case (state)
                IDLE: begin
                    idx          <= '0;
                    skid_full    <= 1'b0;
                    commit_abort <= 1'b0;
                end
                RECEIVE: begin
                    if (cs) begin
                        idx <= '0;
                    end else if (rx_valid) begin
                        idx <= last ? '0 : idx + 1'b1;
                    end
                end
                COMMIT: begin
                    if (last) begin
                        idx          <= stage_wr_en ? IdxW'(1) : '0;
                        skid_full    <= 1'b0;
                        commit_abort <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                        if (cs) begin
                            commit_abort <= 1'b1;
                        end
                        if (rx_ok && !skid_full) begin
                            skid_byte <= rx_data;
                            skid_full <= 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    idx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_command_sequencer.sv
// Directed self-checking bench for command_sequencer with RecordWords=4, FifoDepth=16.
module tb_command_sequencer;
    import beagleg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic [6:0] fifo_size;
    logic       fifo_write_en;
    logic [7:0] fifo_data;
    logic [1:0] state_o;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    logic [7:0] wr_q[$];
    int         wr_cyc[$];

    command_sequencer #(
        .FifoDepth   (16),
        .RecordWords (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cs            (cs),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .fifo_size     (fifo_size),
        .fifo_write_en (fifo_write_en),
        .fifo_data     (fifo_data),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cycle++;
        if (fifo_write_en) begin
            wr_q.push_back(fifo_data);
            wr_cyc.push_back(cycle);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; holds rx_valid for exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_q.delete();
        wr_cyc.delete();
    endtask

    logic [7:0] exp_a [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    logic [7:0] exp_bc[8] = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC1, 8'hC2, 8'hC3, 8'hC4};

    initial begin
        reset     = 1'b1;
        cs        = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        fifo_size = 7'd0;
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_wr_en", 32'(fifo_write_en), 32'd0);
        check("rst_fifo_data", 32'(fifo_data), 32'h00);
        check("rst_tx", 32'(tx_data), 32'h10);
        reset = 1'b0;
        @(negedge clk);

        send_byte(CMD_STATUS);
        check("status_state", 32'(state_o), 32'd0);
        check("status_tx", 32'(tx_data), 32'h10);

        // Full record commit
        clear_log();
        send_byte(CMD_WRITE_FIFO);
        check("wr_cmd_state", 32'(state_o), 32'd1);
        check("wr_receive_tx", 32'(tx_data), 32'h00);
        for (int i = 0; i < 4; i++) send_byte(exp_a[i]);
        check("commit_state", 32'(state_o), 32'd2);
        repeat (5) @(negedge clk);
        check("commit_count", 32'(wr_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_q.size(); i++) check("commit_data", 32'(wr_q[i]), 32'(exp_a[i]));
        if (wr_cyc.size() == 4) check("commit_consec", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
        check("post_commit_state", 32'(state_o), 32'd1);

        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        check("clean_exit_state", 32'(state_o), 32'd0);
        check("clean_exit_tx", 32'(tx_data), 32'h10);

        // Truncated record
        clear_log();
        send_byte(CMD_WRITE_FIFO);
        send_byte(8'h11);
        send_byte(8'h22);
        cs = 1'b1;
        @(negedge clk);
        check("trunc_state", 32'(state_o), 32'd0);
        check("trunc_tx", 32'(tx_data), 32'h50);
        check("trunc_no_wr", 32'(wr_q.size()), 32'd0);
        cs = 1'b0;
        @(negedge clk);
        send_byte(CMD_CLEAR_ERRORS);
        check("clear_tx", 32'(tx_data), 32'h10);

        // FIFO full: record dropped
        fifo_size = 7'd64;
        @(negedge clk);
        check("full_idle_tx", 32'(tx_data), 32'h00);
        clear_log();
        send_byte(CMD_WRITE_FIFO);
        send_byte(8'hE1);
        send_byte(8'hE2);
        send_byte(8'hE3);
        send_byte(8'hE4);
        check("full_state", 32'(state_o), 32'd1);
        repeat (4) @(negedge clk);
        check("full_no_wr", 32'(wr_q.size()), 32'd0);
        cs = 1'b1;
        @(negedge clk);
        check("full_tx", 32'(tx_data), 32'h80);
        fifo_size = 7'd61;
        @(negedge clk);
        check("size61_tx", 32'(tx_data), 32'h80);
        fifo_size = 7'd60;
        @(negedge clk);
        check("size60_tx", 32'(tx_data), 32'h81);
        fifo_size = 7'd0;
        cs = 1'b0;
        @(negedge clk);
        send_byte(CMD_CLEAR_ERRORS);
        check("clear2_tx", 32'(tx_data), 32'h10);

        // Skid byte during COMMIT, plus a second dropped strobe
        clear_log();
        send_byte(CMD_WRITE_FIFO);
        send_byte(8'hB1);
        send_byte(8'hB2);
        send_byte(8'hB3);
        send_byte(8'hB4);
        @(negedge clk);
        send_byte(8'hC1);
        send_byte(8'hC9);
        @(negedge clk);
        check("skid_recv_state", 32'(state_o), 32'd1);
        send_byte(8'hC2);
        send_byte(8'hC3);
        send_byte(8'hC4);
        repeat (5) @(negedge clk);
        check("skid_count", 32'(wr_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++) check("skid_data", 32'(wr_q[i]), 32'(exp_bc[i]));
        cs = 1'b1;
        @(negedge clk);
        check("skid_ovf_tx", 32'(tx_data), 32'h90);
        cs = 1'b0;
        @(negedge clk);

        // Reset in the middle of COMMIT
        clear_log();
        send_byte(CMD_WRITE_FIFO);
        send_byte(8'hD1);
        send_byte(8'hD2);
        send_byte(8'hD3);
        send_byte(8'hD4);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_en", 32'(fifo_write_en), 32'd0);
        check("mid_rst_state", 32'(state_o), 32'd0);
        check("mid_rst_tx", 32'(tx_data), 32'h10);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rst_count", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() >= 2) begin
            check("mid_rst_d1", 32'(wr_q[0]), 32'hD1);
            check("mid_rst_d2", 32'(wr_q[1]), 32'hD2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
